// File: rtl/psram_qspi_responder_pkg.sv
// Shared opcodes and state encoding for the QSPI PSRAM responder.
package psram_pkg;

  localparam logic [7:0] CMD_ENTER_QPI  = 8'h35;
  localparam logic [7:0] CMD_EXIT_QPI   = 8'hF5;
  localparam logic [7:0] CMD_WRITE      = 8'h02;
  localparam logic [7:0] CMD_READ       = 8'h03;
  localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;
  localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD,
    WR,
    IGNORE
  } responder_state_t;

endpackage

// File: rtl/psram_qspi_responder_if.sv
// PSRAM bus between the board master and the responder.
// No valid/ready: a transfer is framed by ce low and paced by sclk edges; the master
// drives sclk/ce/sio_in, the responder drives sio_out/sio_oe after each sclk fall.
interface psram_qspi_if;
  logic       sclk;
  logic       ce;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic [3:0] sio_oe;

  modport master (output sclk, output ce, output sio_in, input sio_out, input sio_oe);
  modport slave  (input sclk, input ce, input sio_in, output sio_out, output sio_oe);
endinterface

// File: rtl/psram_qspi_responder_bus_sync.sv
// Synchronizes the asynchronous PSRAM bus into clk and flags sclk edges and ce falls.
module psram_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_sclk,
  input  logic       i_ce,
  input  logic [3:0] i_sio,
  output logic       o_sclk_rise,
  output logic       o_sclk_fall,
  output logic       o_ce_s,
  output logic       o_ce_fall,
  output logic [3:0] o_sio_s
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ce_sync;
  logic [3:0]             r_sio_sync [SYNC_STAGES];
  logic                   r_sclk_prev;
  logic                   r_ce_prev;

  // sio goes through the same depth as sclk so data stays aligned with its edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_ce_sync   <= '1;
      r_sclk_prev <= 1'b0;
      r_ce_prev   <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) r_sio_sync[i] <= '0;
    end else begin
      r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_ce_sync     <= {r_ce_sync[SYNC_STAGES-2:0], i_ce};
      r_sio_sync[0] <= i_sio;
      for (int i = 1; i < SYNC_STAGES; i++) r_sio_sync[i] <= r_sio_sync[i-1];
      r_sclk_prev   <= r_sclk_sync[SYNC_STAGES-1];
      r_ce_prev     <= r_ce_sync[SYNC_STAGES-1];
    end
  end

  assign o_ce_s      = r_ce_sync[SYNC_STAGES-1];
  assign o_sio_s     = r_sio_sync[SYNC_STAGES-1];
  assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
  assign o_ce_fall   = ~r_ce_sync[SYNC_STAGES-1] & r_ce_prev;

endmodule

// File: rtl/psram_qspi_responder.sv
// QSPI PSRAM responder: decodes SPI/QPI commands from an oversampled bus and serves
// reads/writes from an internal byte array.
module psram_qspi_responder
  import psram_pkg::*;
#(
  parameter  int MEM_DEPTH   = 1024,
  parameter  int WAIT_CYCLES = 6,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  psram_qspi_if.slave      bus,
  output logic             qpi_mode,
  output logic             busy,
  output logic             cmd_error,
  input  logic [AW-1:0]    bd_addr,
  output logic [7:0]       bd_data,
  output responder_state_t state
);

  localparam logic [4:0] DUMMY_LAST = 5'(WAIT_CYCLES - 1);

  logic             w_rise, w_fall, w_ce_s, w_ce_fall;
  logic [3:0]       w_sio;
  responder_state_t r_state;
  logic [4:0]       r_cnt;
  logic [7:0]       r_sh;
  logic [7:0]       r_cmd;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    r_ptr;
  logic             r_qpi;
  logic             r_cmd_error;
  logic [3:0]       r_sio_out;
  logic [3:0]       r_sio_oe;
  logic [7:0]       r_mem [MEM_DEPTH];
  logic [7:0]       w_sh_in;
  logic [AW-1:0]    w_addr_in;
  logic [AW-1:0]    w_ptr_inc;
  logic [4:0]       w_byte_last;
  logic [4:0]       w_addr_last;
  logic             w_byte_done;
  logic             w_mem_we;

  psram_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset       (reset),
    .i_sclk      (bus.sclk),
    .i_ce        (bus.ce),
    .i_sio       (bus.sio_in),
    .o_sclk_rise (w_rise),
    .o_sclk_fall (w_fall),
    .o_ce_s      (w_ce_s),
    .o_ce_fall   (w_ce_fall),
    .o_sio_s     (w_sio)
  );

  // Only the low AW address bits are kept; upper address bits shift straight out.
  assign w_sh_in     = r_qpi ? {r_sh[3:0], w_sio} : {r_sh[6:0], w_sio[0]};
  assign w_addr_in   = r_qpi ? {r_addr[AW-5:0], w_sio} : {r_addr[AW-2:0], w_sio[0]};
  assign w_ptr_inc   = r_ptr + AW'(1);
  assign w_byte_last = r_qpi ? 5'd1 : 5'd7;
  assign w_addr_last = r_qpi ? 5'd5 : 5'd23;
  assign w_byte_done = (r_cnt == w_byte_last);
  assign w_mem_we    = !reset && !w_ce_s && (r_state == WR) && w_rise && w_byte_done;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_ptr] <= w_sh_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_ptr       <= '0;
      r_qpi       <= 1'b0;
      r_cmd_error <= 1'b0;
      r_sio_out   <= '0;
      r_sio_oe    <= '0;
    end else begin
      r_cmd_error <= 1'b0;
      // ce high aborts anything, including an sclk edge seen in the same cycle
      if (w_ce_s) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_sio_oe  <= '0;
        r_sio_out <= '0;
      end else begin
        case (r_state)
          IDLE: if (w_ce_fall) begin
            r_state <= CMD;
            r_cnt   <= '0;
          end
          CMD: if (w_rise) begin
            r_sh <= w_sh_in;
            if (w_byte_done) begin
              r_cnt <= '0;
              r_cmd <= w_sh_in;
              if (!r_qpi && w_sh_in == CMD_ENTER_QPI) begin
                r_qpi   <= 1'b1;
                r_state <= IGNORE;
              end else if (r_qpi && w_sh_in == CMD_EXIT_QPI) begin
                r_qpi   <= 1'b0;
                r_state <= IGNORE;
              end else if ((!r_qpi && (w_sh_in == CMD_WRITE || w_sh_in == CMD_READ)) ||
                           (r_qpi && (w_sh_in == CMD_QUAD_WRITE || w_sh_in == CMD_QUAD_READ))) begin
                r_state <= ADDR;
              end else begin
                r_cmd_error <= 1'b1;
                r_state     <= IGNORE;
              end
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          ADDR: if (w_rise) begin
            r_addr <= w_addr_in;
            if (r_cnt == w_addr_last) begin
              r_cnt <= '0;
              r_ptr <= w_addr_in;
              if (r_cmd == CMD_QUAD_READ) begin
                r_state <= DUMMY;
              end else if (r_cmd == CMD_READ) begin
                r_state <= RD;
                r_sh    <= r_mem[w_addr_in];
              end else begin
                r_state <= WR;
              end
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          DUMMY: if (w_rise) begin
            if (r_cnt == DUMMY_LAST) begin
              r_cnt   <= '0;
              r_state <= RD;
              r_sh    <= r_mem[r_ptr];
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          RD: if (w_fall) begin
            r_sio_oe  <= r_qpi ? 4'b1111 : 4'b0010;
            r_sio_out <= r_qpi ? r_sh[7:4] : {2'b00, r_sh[7], 1'b0};
            if (w_byte_done) begin
              r_cnt <= '0;
              r_ptr <= w_ptr_inc;
              r_sh  <= r_mem[w_ptr_inc];
            end else begin
              r_cnt <= r_cnt + 5'd1;
              r_sh  <= r_qpi ? {r_sh[3:0], 4'b0000} : {r_sh[6:0], 1'b0};
            end
          end
          WR: if (w_rise) begin
            r_sh <= w_sh_in;
            if (w_byte_done) begin
              r_cnt <= '0;
              r_ptr <= w_ptr_inc;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          IGNORE: r_sio_oe <= '0;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sio_out = r_sio_out;
  assign bus.sio_oe  = r_sio_oe;
  assign qpi_mode    = r_qpi;
  assign cmd_error   = r_cmd_error;
  assign busy        = (r_state == ADDR) || (r_state == DUMMY) || (r_state == RD) || (r_state == WR);
  assign state       = r_state;
  assign bd_data     = r_mem[bd_addr];

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Bench for psram_qspi_responder: hand-written bus sequences, an opcode decode table and
// randomized SPI/QPI traffic checked against a byte-array model of the memory.
module tb_psram_qspi_responder;
  import psram_pkg::*;

  localparam int D    = 1024;
  localparam int AW   = 10;
  localparam int SYNC = 2;
  localparam int WAIT = 6;
  localparam int HALF = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             qpi_mode, busy, cmd_error;
  logic [AW-1:0]    bd_addr;
  logic [7:0]       bd_data;
  responder_state_t state;

  psram_qspi_if bus();

  psram_qspi_responder #(.MEM_DEPTH(D), .WAIT_CYCLES(WAIT), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .qpi_mode  (qpi_mode),
    .busy      (busy),
    .cmd_error (cmd_error),
    .bd_addr   (bd_addr),
    .bd_data   (bd_data),
    .state     (state)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         err_cycles = 0;
  logic       m_qpi = 1'b0;
  logic [7:0] exp_mem [D];
  logic [7:0] wbuf [64];

  always @(negedge clk) if (cmd_error === 1'b1) err_cycles++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic [3:0] v);
    bus.sio_in = v;
    wait_clk(HALF);
    bus.sclk = 1'b1;
    wait_clk(HALF);
    bus.sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (m_qpi) begin
      clk_bit(b[7:4]);
      clk_bit(b[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) clk_bit({3'b000, b[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    if (m_qpi) for (int i = 5; i >= 0; i--) clk_bit(a[i*4 +: 4]);
    else       for (int i = 23; i >= 0; i--) clk_bit({3'b000, a[i]});
  endtask

  task automatic begin_txn(input logic [7:0] op);
    bus.ce = 1'b0;
    wait_clk(4);
    send_byte(op);
  endtask

  task automatic end_txn();
    bus.ce = 1'b1;
    bus.sio_in = '0;
    wait_clk(SYNC + 1);
    check("oe_after_ce", 32'(bus.sio_oe), 32'h0);
    check("state_after_ce", 32'(state), 32'(IDLE));
    check("busy_after_ce", 32'(busy), 32'h0);
    wait_clk(2);
  endtask

  task automatic bd_check(input int idx);
    bd_addr = AW'(idx);
    wait_clk(1);
    check("bd_data", 32'(bd_data), 32'(exp_mem[idx]));
  endtask

  task automatic read_byte(output logic [7:0] b);
    b = '0;
    for (int i = 0; i < (m_qpi ? 2 : 8); i++) begin
      wait_clk(HALF);
      check("rd_oe", 32'(bus.sio_oe), m_qpi ? 32'hF : 32'h2);
      check("rd_busy", 32'(busy), 32'h1);
      b = m_qpi ? {b[3:0], bus.sio_out} : {b[6:0], bus.sio_out[1]};
      bus.sclk = 1'b1;
      wait_clk(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic do_write(input logic [23:0] a, input int n);
    begin_txn(m_qpi ? CMD_QUAD_WRITE : CMD_WRITE);
    send_addr(a);
    check("wr_busy", 32'(busy), 32'h1);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i]);
      exp_mem[(int'(a[AW-1:0]) + i) % D] = wbuf[i];
    end
    end_txn();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] b;
    begin_txn(m_qpi ? CMD_QUAD_READ : CMD_READ);
    send_addr(a);
    if (m_qpi) begin
      for (int k = 0; k < WAIT; k++) begin
        bus.sio_in = '0;
        wait_clk(HALF);
        check("dummy_oe", 32'(bus.sio_oe), 32'h0);
        check("dummy_busy", 32'(busy), 32'h1);
        bus.sclk = 1'b1;
        wait_clk(HALF);
        bus.sclk = 1'b0;
      end
    end
    for (int i = 0; i < n; i++) begin
      read_byte(b);
      check("rd_data", 32'(b), 32'(exp_mem[(int'(a[AW-1:0]) + i) % D]));
    end
    end_txn();
  endtask

  task automatic set_mode(input logic q);
    int e0;
    e0 = err_cycles;
    begin_txn(q ? CMD_ENTER_QPI : CMD_EXIT_QPI);
    m_qpi = q;
    wait_clk(2);
    check("mode_qpi", 32'(qpi_mode), 32'(q));
    check("mode_no_err", 32'(err_cycles - e0), 32'h0);
    end_txn();
  endtask

  typedef struct {
    logic [7:0] op;
    logic       exp_err;
    logic       exp_qpi;
  } dec_vec_t;

  dec_vec_t dvec [10];

  initial begin
    int         kind;
    int         n;
    int         e0;
    logic [23:0] a;

    dvec[0] = '{8'h9F, 1'b1, 1'b0};
    dvec[1] = '{8'h38, 1'b1, 1'b0};
    dvec[2] = '{8'hF5, 1'b1, 1'b0};
    dvec[3] = '{8'hEB, 1'b1, 1'b0};
    dvec[4] = '{8'h35, 1'b0, 1'b1};
    dvec[5] = '{8'h35, 1'b1, 1'b1};
    dvec[6] = '{8'h02, 1'b1, 1'b1};
    dvec[7] = '{8'h03, 1'b1, 1'b1};
    dvec[8] = '{8'h9F, 1'b1, 1'b1};
    dvec[9] = '{8'hF5, 1'b0, 1'b0};

    bus.sclk = 1'b0;
    bus.ce = 1'b1;
    bus.sio_in = '0;
    bd_addr = '0;
    reset = 1'b1;
    wait_clk(5);
    check("rst_sio_out", 32'(bus.sio_out), 32'h0);
    check("rst_sio_oe", 32'(bus.sio_oe), 32'h0);
    check("rst_qpi", 32'(qpi_mode), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cmd_error", 32'(cmd_error), 32'h0);
    check("rst_state", 32'(state), 32'(IDLE));
    reset = 1'b0;
    wait_clk(5);

    // SPI write then read back at address 0
    wbuf[0] = 8'h5A;
    do_write(24'h000000, 1);
    do_read(24'h000000, 1);
    check("spi_qpi_mode", 32'(qpi_mode), 32'h0);
    bd_check(0);

    // enter QPI, quad write two bytes at 0x10
    set_mode(1'b1);
    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    do_write(24'h000010, 2);
    bd_check(16);
    bd_check(17);
    check("qpi_mode_on", 32'(qpi_mode), 32'h1);

    // quad read with dummy cycles
    do_read(24'h000010, 2);

    // write across the top of memory
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    do_write(24'(D - 1), 2);
    bd_check(D - 1);
    bd_check(0);

    // partial byte aborted by ce high must not land
    wbuf[0] = 8'h77;
    do_write(24'h000020, 1);
    begin_txn(CMD_QUAD_WRITE);
    send_addr(24'h000020);
    clk_bit(4'hE);
    end_txn();
    bd_check(32);
    do_read(24'h000020, 1);

    // preload a window around address 0 for the random phase
    for (int i = 0; i < 48; i++) wbuf[i] = 8'($urandom);
    do_write(24'(D - 16), 48);
    bd_check(D - 16);
    bd_check(31);

    // reset in the middle of a quad write
    begin_txn(CMD_QUAD_WRITE);
    send_addr(24'h000040);
    clk_bit(4'h9);
    reset = 1'b1;
    bus.ce = 1'b1;
    wait_clk(1);
    check("midrst_state", 32'(state), 32'(IDLE));
    check("midrst_qpi", 32'(qpi_mode), 32'h0);
    wait_clk(2);
    reset = 1'b0;
    m_qpi = 1'b0;
    wait_clk(5);

    // opcode decode table
    for (int v = 0; v < 10; v++) begin
      e0 = err_cycles;
      begin_txn(dvec[v].op);
      wait_clk(2);
      check("dec_err", 32'(err_cycles - e0), 32'(dvec[v].exp_err));
      check("dec_state", 32'(state), 32'(IGNORE));
      check("dec_oe", 32'(bus.sio_oe), 32'h0);
      check("dec_busy", 32'(busy), 32'h0);
      end_txn();
      check("dec_qpi", 32'(qpi_mode), 32'(dvec[v].exp_qpi));
      m_qpi = dvec[v].exp_qpi;
    end

    // back in SPI after exit-QPI
    do_read(24'h000010, 2);

    // randomized traffic inside the preloaded window
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 9);
      n = $urandom_range(1, 4);
      a = 24'($urandom);
      a[AW-1:0] = AW'((D - 8 + $urandom_range(0, 23)) % D);
      if (kind == 0) begin
        set_mode(!m_qpi);
      end else if (kind <= 4) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        do_write(a, n);
        bd_check(int'(a[AW-1:0]));
      end else begin
        do_read(a, n);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
